// File: rtl/mem_line_arbiter.sv
// Shares one cache-line memory port between the I-cache and D-cache with round-robin grant.
// Latency: mem_read/mem_write rise one cycle after the request is sampled; resp is same-cycle with mem_resp.
// Backpressure: requesters hold their request until resp; requests are not sampled during SERVE or GAP.
module mem_line_arbiter #(
    parameter int LINE_W      = 256,
    parameter int ADDR_W      = 32,
    parameter int GAP_CYCLES  = 1,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    input  logic              d_read,
    input  logic              d_write,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              err_timeout
);

    localparam int GAP_W  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int WDOG_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;

    logic d_req;
    logic pick_d;

    // On a tie the requester that did not win last time takes the port.
    assign d_req  = d_read | d_write;
    assign pick_d = d_req & (~i_read | (last_grant_q == OWN_I));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        gap_cnt_d    = gap_cnt_q;
        wdog_cnt_d   = wdog_cnt_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_read || d_req) begin
                    owner_d      = pick_d;
                    last_grant_d = pick_d;
                    addr_d       = pick_d ? d_addr : i_addr;
                    wdata_d      = pick_d ? d_wdata : '0;
                    mem_write_d  = pick_d & d_write;
                    mem_read_d   = ~(pick_d & d_write);
                    wdog_cnt_d   = '0;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (mem_resp) begin
                    i_resp      = (owner_q == OWN_I);
                    d_resp      = (owner_q == OWN_D);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    gap_cnt_d   = GAP_W'(GAP_CYCLES);
                    state_d     = ST_GAP;
                end else if ((WDOG_CYCLES != 0) && !err_q) begin
                    // Counter stops once the flag is set, so it never wraps.
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                    if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        i_rdata = '0;
        d_rdata = '0;
        if (state_q == ST_SERVE) begin
            if (owner_q == OWN_D) begin
                d_rdata = mem_rdata;
            end else begin
                i_rdata = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            gap_cnt_q    <= '0;
            wdog_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            gap_cnt_q    <= gap_cnt_d;
            wdog_cnt_q   <= wdog_cnt_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: adapter responder, transaction-level reference model, directed tests.
module tb_mem_line_arbiter;

    localparam int LW   = 256;
    localparam int AW   = 32;
    localparam int GAP  = 1;
    localparam int WDOG = 16;
    localparam int LAT  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_addr = '0;
    logic          i_read = 1'b0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic          mem_resp = 1'b0;
    logic [LW-1:0] mem_rdata = '0;
    logic          err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mem_line_arbiter #(
        .LINE_W(LW), .ADDR_W(AW), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_read(d_read), .d_write(d_write),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Adapter stand-in: answers on the LAT-th cycle a request is held.
    logic [LW-1:0] mem_model [logic [AW-1:0]];
    bit resp_en = 1'b1;
    int lat_cnt = 0;

    function automatic logic [LW-1:0] rd_line(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {8{a}};
    endfunction

    always @(posedge clk) begin
        #1;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        if ((mem_read || mem_write) && resp_en) begin
            lat_cnt++;
            if (lat_cnt == LAT) begin
                mem_resp = 1'b1;
                if (mem_write) mem_model[mem_addr] = mem_wdata;
                else           mem_rdata = rd_line(mem_addr);
                lat_cnt = 0;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    // Reference model: which transaction is on the port and how long it has waited.
    int            ph = 0;          // 0 free, 1 transaction on port, 2 idle gap
    bit            m_own_d = 1'b0;
    bit            m_last_d = 1'b0;
    bit            m_wr = 1'b0;
    bit            m_err = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    int            m_gap_left = 0;
    int            m_stall = 0;

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; m_last_d = 1'b0; m_err = 1'b0;
        end else if (ph == 0) begin
            if (i_read || d_read || d_write) begin
                m_own_d  = (d_read || d_write) && (!i_read || !m_last_d);
                m_last_d = m_own_d;
                m_wr     = m_own_d && d_write;
                m_addr   = m_own_d ? d_addr : i_addr;
                m_wdata  = d_wdata;
                m_stall  = 0;
                ph       = 1;
            end
        end else if (ph == 1) begin
            if (mem_resp) begin
                ph = 2; m_gap_left = GAP;
            end else begin
                m_stall++;
                if (WDOG != 0 && m_stall >= WDOG) m_err = 1'b1;
            end
        end else begin
            m_gap_left--;
            if (m_gap_left == 0) ph = 0;
        end
    end

    always @(negedge clk) begin
        bit sv;
        sv = (ph == 1);
        chk("mem_read", mem_read, sv && !m_wr);
        chk("mem_write", mem_write, sv && m_wr);
        chk("i_resp", i_resp, sv && mem_resp && !m_own_d);
        chk("d_resp", d_resp, sv && mem_resp && m_own_d);
        chk("i_rdata", i_rdata, (sv && !m_own_d) ? mem_rdata : '0);
        chk("d_rdata", d_rdata, (sv && m_own_d) ? mem_rdata : '0);
        chk("err_timeout", err_timeout, m_err);
        if (sv) begin
            chk("mem_addr", mem_addr, m_addr);
            if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // who: 0 = I-cache, 1 = D-cache, -1 = no response within budget
    task automatic wait_any(input string name, input int budget, output int who, output int n,
                            output logic [LW-1:0] rd);
        bit done;
        done = 1'b0; who = -1; n = 0; rd = '0;
        for (int k = 1; k <= budget; k++) begin
            if (!done) begin
                @(negedge clk);
                if (i_resp || d_resp) begin
                    who  = d_resp ? 1 : 0;
                    n    = k;
                    rd   = d_resp ? d_rdata : i_rdata;
                    done = 1'b1;
                end
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no resp within %0d cycles", name, budget);
        end
    endtask

    logic [LW-1:0] w2, w3, a5, rd;
    int who, n, low, serve_k;
    bit seen;

    initial begin
        w2 = {8{32'hDEAD_0002}};
        w3 = {4{64'h0123_4567_89AB_CDEF}};
        a5 = {32{8'hA5}};
        mem_model[32'h0000_1000] = a5;

        idle(3);
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_err", err_timeout, 1'b0);
        step(); rst = 1'b0;
        idle(2);

        // 1: lone I-cache read
        i_addr = 32'h0000_1000; i_read = 1'b1;
        @(negedge clk);
        chk("t1_mem_read_sample_cycle", mem_read, 1'b0);
        @(negedge clk);
        chk("t1_mem_read_next_cycle", mem_read, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1000);
        wait_any("t1_wait", 20, who, n, rd);
        chk("t1_who", who, 0);
        chk("t1_latency", n, 5);
        chk("t1_rdata", rd, a5);
        step(); i_read = 1'b0;
        idle(3);

        // 2: simultaneous request straight after reset goes to D
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        i_addr = 32'h0000_3000; i_read = 1'b1;
        d_addr = 32'h0000_2400; d_wdata = w2; d_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_mem_write", mem_write, 1'b1);
        chk("t2_mem_read", mem_read, 1'b0);
        chk("t2_mem_wdata", mem_wdata, w2);
        wait_any("t2_wait_d", 20, who, n, rd);
        chk("t2_first_who", who, 1);
        step(); d_write = 1'b0;
        wait_any("t2_wait_i", 30, who, n, rd);
        chk("t2_second_who", who, 0);
        chk("t2_i_rdata", rd, {8{32'h0000_3000}});
        step(); i_read = 1'b0;
        idle(3);
        // last grant was I, so the next tie goes to D
        d_addr = 32'h0000_2400; d_read = 1'b1; i_read = 1'b1;
        wait_any("t2_tie2", 20, who, n, rd);
        chk("t2_tie2_who", who, 1);
        chk("t2_readback", rd, w2);
        step(); d_read = 1'b0;
        wait_any("t2_tie2_i", 30, who, n, rd);
        step(); i_read = 1'b0;
        idle(3);
        d_read = 1'b1;
        wait_any("t2_d_only", 20, who, n, rd);
        step(); d_read = 1'b0;
        idle(3);
        // last grant was D, so this tie goes to I
        d_read = 1'b1; i_read = 1'b1;
        wait_any("t2_tie3", 20, who, n, rd);
        chk("t2_tie3_who", who, 0);
        step(); i_read = 1'b0;
        wait_any("t2_tie3_d", 30, who, n, rd);
        step(); d_read = 1'b0;
        idle(3);

        // 3: write then read of the same line back to back
        d_addr = 32'h0000_2000; d_wdata = w3; d_write = 1'b1;
        wait_any("t3_write", 20, who, n, rd);
        chk("t3_write_who", who, 1);
        step(); d_write = 1'b0; d_read = 1'b1;
        low = 0; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!seen) begin
                @(negedge clk);
                if (mem_read || mem_write) seen = 1'b1;
                else low++;
            end
        end
        // GAP state cycles plus the idle cycle in which the read is sampled
        chk("t3_low_cycles", low, GAP + 1);
        wait_any("t3_read", 20, who, n, rd);
        chk("t3_read_who", who, 1);
        chk("t3_readback", rd, w3);
        step(); d_read = 1'b0;
        idle(3);

        // 4: request dropped mid-transaction, other address lines toggling
        d_addr = 32'h0000_5000; d_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        step(); d_read = 1'b0; i_addr = 32'hFFFF_0000;
        @(negedge clk);
        chk("t4_mem_addr_held", mem_addr, 32'h0000_5000);
        chk("t4_mem_read_held", mem_read, 1'b1);
        step(); i_addr = 32'h0000_0040; d_addr = 32'h0000_7000;
        wait_any("t4_wait", 20, who, n, rd);
        chk("t4_who", who, 1);
        chk("t4_rdata", rd, {8{32'h0000_5000}});
        idle(3);

        // 5: adapter never answers
        @(negedge clk);
        resp_en = 1'b0;
        step(); d_addr = 32'h0000_6000; d_read = 1'b1;
        serve_k = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (mem_read) begin
                serve_k++;
                if (serve_k == WDOG)     chk("t5_err_before", err_timeout, 1'b0);
                if (serve_k == WDOG + 1) chk("t5_err_after", err_timeout, 1'b1);
            end
        end
        chk("t5_err_sticky", err_timeout, 1'b1);

        // 6: reset while the transaction is still outstanding
        step(); rst = 1'b1; d_read = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_mem_read", mem_read, 1'b0);
        chk("t6_d_resp", d_resp, 1'b0);
        chk("t6_err", err_timeout, 1'b0);
        resp_en = 1'b1;
        step(); i_addr = 32'h0000_1000; i_read = 1'b1;
        wait_any("t6_after", 20, who, n, rd);
        chk("t6_after_who", who, 0);
        chk("t6_after_rdata", rd, a5);
        step(); i_read = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
